// File: rtl/countdown_timer_pkg.sv
// Shared types and default sizing for the countdown timer block.
package countdown_timer_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DIV   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status pin bundle between the timer and whatever drives it.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = countdown_timer_pkg::DEF_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic             out_en_n;
    logic [WIDTH-1:0] count_out;
    logic             busy;
    logic             done;
    logic             expired;

    modport master (
        output load, load_value, start, pause, auto_reload, out_en_n,
        input  count_out, busy, done, expired
    );

    modport slave (
        input  load, load_value, start, pause, auto_reload, out_en_n,
        output count_out, busy, done, expired
    );
endinterface

// File: rtl/countdown_prescaler.sv
// DIV-modulo counter; o_tick_c marks the enabled cycle on which it wraps.
module countdown_prescaler #(
    parameter int unsigned DIV = countdown_timer_pkg::DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick_c = i_en && (r_cnt == LAST);

    // Count is held, not cleared, while disabled so a pause resumes mid-period.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick_c ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled decrement, pause/resume, auto-reload and expiry pulse.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV   = DEF_DIV
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_expired;

    logic w_presc_en;
    logic w_presc_clr;
    logic w_tick;
    logic w_restart;

    assign w_restart   = (r_state == ST_DONE) && !bus.pause && bus.start && (r_reload != '0);
    assign w_presc_en  = (r_state == ST_RUN) && !bus.load && !bus.pause;
    assign w_presc_clr = bus.load || w_restart;

    countdown_prescaler #(.DIV(DIV)) u_presc (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_presc_en),
        .i_clr    (w_presc_clr),
        .o_tick_c (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (bus.load) begin
                r_count  <= bus.load_value;
                r_reload <= bus.load_value;
                r_state  <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE, ST_HOLD: begin
                        if (!bus.pause && bus.start) begin
                            if (r_count != '0) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_state   <= ST_DONE;
                                r_expired <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bus.pause) begin
                            r_state <= ST_HOLD;
                        end else if (w_tick) begin
                            // Reaching zero either reloads in place or parks in DONE.
                            if (r_count == WIDTH'(1)) begin
                                r_expired <= 1'b1;
                                if (bus.auto_reload && (r_reload != '0)) begin
                                    r_count <= r_reload;
                                end else begin
                                    r_count <= '0;
                                    r_state <= ST_DONE;
                                end
                            end else if (r_count != '0) begin
                                r_count <= r_count - WIDTH'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (w_restart) begin
                            r_count <= r_reload;
                            r_state <= ST_RUN;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.expired   = r_expired;
    assign bus.count_out = bus.out_en_n ? '0 : r_count;
endmodule
